// File: rtl/jtframe_romrsp_pkg.sv
// Shared types and constants for the jtframe ROM responder.
package jtframe_romrsp_pkg;

  localparam int HW   = 16;
  localparam int NCLI = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_WAIT_DST = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_POST     = 3'd4
  } state_t;

  // Watchdog counter width: wide enough for the limit, never narrower than 8 bits
  function automatic int unsigned cnt_width(int unsigned tout);
    return ($clog2(tout + 1) > 8) ? $clog2(tout + 1) : 8;
  endfunction

endpackage

// File: rtl/jtframe_romrsp_if.sv
// Client request/response and SDRAM controller signals of the ROM responder.
interface jtframe_romrsp_if #(
  parameter int AW = 22
);
  import jtframe_romrsp_pkg::*;

  logic          req0;
  logic [AW-1:0] addr0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [2*HW-1:0] din;
  logic          din_ok;
  logic          we0;
  logic          we1;
  logic          sd_rd;
  logic [AW-1:0] sd_addr;
  logic          sd_ack;
  logic          sd_dst;
  logic          sd_rdy;
  logic [HW-1:0] sd_din;
  logic          err;

  // responder side
  modport slave (
    input  req0, addr0, req1, addr1, sd_ack, sd_dst, sd_rdy, sd_din,
    output din, din_ok, we0, we1, sd_rd, sd_addr, err
  );

  // clients plus SDRAM controller side
  modport master (
    output req0, addr0, req1, addr1, sd_ack, sd_dst, sd_rdy, sd_din,
    input  din, din_ok, we0, we1, sd_rd, sd_addr, err
  );

endinterface

// File: rtl/jtframe_romrsp_arb.sv
// Combinational 2-way arbiter: round-robin on ties when rr is set, else client 0 wins.
module jtframe_romrsp_arb
  import jtframe_romrsp_pkg::*;
(
  input  logic [NCLI-1:0] req,
  input  logic            rr,
  input  logic            last,
  output logic            gnt,
  output logic            valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) gnt = rr & ~last;
    else              gnt = req[1];
  end

endmodule

// File: rtl/jtframe_romrsp.sv
// SDRAM-side ROM responder for two clients; one 2x16-bit read burst per grant.
// Optional watchdog enabled by defining JTFRAME_ROMRSP_TIMEOUT_EN.
module jtframe_romrsp
  import jtframe_romrsp_pkg::*;
#(
  parameter int AW   = 22,
  parameter int RR   = 1,
  parameter int TOUT = 255
)(
  input  logic clk,
  input  logic rst_n,
  jtframe_romrsp_if.slave bus
);

  if (TOUT < 16) begin : g_bad_tout
    $error("jtframe_romrsp: TOUT must be at least 16");
  end

  state_t          st, nx;
  logic            gnt, last;
  logic            arb_gnt, arb_valid;
  logic [HW-1:0]   low;
  logic [2*HW-1:0] din_r;
  logic [AW-1:0]   addr_r;
  logic            tout_hit;
  logic            sd_rd_c, din_ok_c, we0_c, we1_c;

  jtframe_romrsp_arb u_arb (
    .req   ({bus.req1, bus.req0}),
    .rr    (RR != 0),
    .last  (last),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

`ifdef JTFRAME_ROMRSP_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(TOUT);
  logic [CW-1:0] cnt;
  logic          in_wait;
  logic          err_r;

  assign in_wait  = (st == ST_WAIT_ACK) || (st == ST_WAIT_DST) || (st == ST_WAIT_RDY);
  assign tout_hit = in_wait && (cnt == CW'(TOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      if (!in_wait || st != nx) cnt <= '0;
      else                      cnt <= cnt + CW'(1);
      // only the watchdog can move a wait state back to IDLE
      if (in_wait && nx == ST_IDLE) err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  assign tout_hit = 1'b0;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= nx;
  end

  always_comb begin
    nx = st;
    case (st)
      ST_IDLE:     if (arb_valid) nx = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (bus.sd_ack) nx = bus.sd_dst ? ST_WAIT_RDY : ST_WAIT_DST;
        else if (tout_hit) nx = ST_IDLE;
      end
      ST_WAIT_DST: begin
        if (bus.sd_dst)    nx = ST_WAIT_RDY;
        else if (tout_hit) nx = ST_IDLE;
      end
      ST_WAIT_RDY: begin
        if (bus.sd_rdy)    nx = ST_POST;
        else if (tout_hit) nx = ST_IDLE;
      end
      ST_POST:     nx = ST_IDLE;
      default:     nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_c  = 1'b0;
    din_ok_c = 1'b0;
    we0_c    = 1'b0;
    we1_c    = 1'b0;
    case (st)
      ST_WAIT_ACK: sd_rd_c = 1'b1;
      ST_POST: begin
        din_ok_c = 1'b1;
        we0_c    = ~gnt;
        we1_c    = gnt;
      end
      default: ;
    endcase
  end

  // Grant, address and data capture; last starts at 1 so client 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= 1'b0;
      last   <= 1'b1;
      addr_r <= '0;
      low    <= '0;
      din_r  <= '0;
    end else begin
      if (st == ST_IDLE && arb_valid) begin
        gnt    <= arb_gnt;
        last   <= arb_gnt;
        addr_r <= arb_gnt ? bus.addr1 : bus.addr0;
      end
      if ((st == ST_WAIT_ACK && bus.sd_ack && bus.sd_dst) ||
          (st == ST_WAIT_DST && bus.sd_dst))
        low <= bus.sd_din;
      if (st == ST_WAIT_RDY && bus.sd_rdy)
        din_r <= {bus.sd_din, low};
    end
  end

  assign bus.sd_rd   = sd_rd_c;
  assign bus.sd_addr = addr_r;
  assign bus.din     = din_r;
  assign bus.din_ok  = din_ok_c;
  assign bus.we0     = we0_c;
  assign bus.we1     = we1_c;

endmodule

// File: tb/tb_jtframe_romrsp.sv
// Scoreboard bench: a round-robin and a fixed-priority responder share one stimulus stream.
module tb_jtframe_romrsp;
  import jtframe_romrsp_pkg::*;

  localparam int AW   = 22;
  localparam int TOUT = 16;

  typedef struct packed {
    logic        we1;
    logic        we0;
    logic [31:0] din;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          sd_ack, sd_dst, sd_rdy;
  logic [15:0]   sd_din;

  int   tests = 0;
  int   fails = 0;
  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  jtframe_romrsp_if #(.AW(AW)) b1 ();
  jtframe_romrsp_if #(.AW(AW)) b0 ();

  assign b1.req0 = req0;   assign b0.req0 = req0;
  assign b1.addr0 = addr0; assign b0.addr0 = addr0;
  assign b1.req1 = req1;   assign b0.req1 = req1;
  assign b1.addr1 = addr1; assign b0.addr1 = addr1;
  assign b1.sd_ack = sd_ack; assign b0.sd_ack = sd_ack;
  assign b1.sd_dst = sd_dst; assign b0.sd_dst = sd_dst;
  assign b1.sd_rdy = sd_rdy; assign b0.sd_rdy = sd_rdy;
  assign b1.sd_din = sd_din; assign b0.sd_din = sd_din;

  jtframe_romrsp #(.AW(AW), .RR(1), .TOUT(TOUT)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(b1));
  jtframe_romrsp #(.AW(AW), .RR(0), .TOUT(TOUT)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(b0));

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic c, logic [31:0] d);
    exp_t e;
    e.we1 = c;
    e.we0 = ~c;
    e.din = d;
    return e;
  endfunction

  task automatic expect2(logic c_rr, logic c_fp, logic [31:0] d);
    q1.push_back(mk(c_rr, d));
    q0.push_back(mk(c_fp, d));
  endtask

  // Monitors: pop an expectation on every din_ok
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (b1.din_ok) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL rr_unexpected_din_ok: got din=%h expected no strobe", b1.din);
        end else begin
          e = q1.pop_front();
          check("rr_rsp", {30'b0, b1.we1, b1.we0, b1.din}, {30'b0, e.we1, e.we0, e.din});
        end
      end
      if (b0.din_ok) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL fp_unexpected_din_ok: got din=%h expected no strobe", b0.din);
        end else begin
          e = q0.pop_front();
          check("fp_rsp", {30'b0, b0.we1, b0.we0, b0.din}, {30'b0, e.we1, e.we0, e.din});
        end
      end
      if ((b1.we0 & b1.we1) | ((b1.we0 | b1.we1) & ~b1.din_ok)) begin
        fails++;
        $display("FAIL rr_we_excl: got we0=%b we1=%b din_ok=%b expected one-hot with din_ok", b1.we0, b1.we1, b1.din_ok);
      end
      if ((b0.we0 & b0.we1) | ((b0.we0 | b0.we1) & ~b0.din_ok)) begin
        fails++;
        $display("FAIL fp_we_excl: got we0=%b we1=%b din_ok=%b expected one-hot with din_ok", b0.we0, b0.we1, b0.din_ok);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (b1.sd_rd) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_sd_rd: got no sd_rd expected sd_rd within 64 cycles");
    end
  endtask

  // SDRAM controller model for one burst; returns with both DUTs in POST
  task automatic serve(int ack_dly, bit same, bit stray, bit drop,
                       logic [15:0] lo, logic [15:0] hi,
                       logic [AW-1:0] a_rr, logic [AW-1:0] a_fp);
    bit ok;
    wait_rd(ok);
    if (!ok) return;
    check("rr_sd_addr", b1.sd_addr, a_rr);
    check("fp_sd_addr", b0.sd_addr, a_fp);
    if (drop) begin
      tick();
      req0  = 1'b0;
      addr0 = 22'h00055;
    end
    repeat (ack_dly) tick();
    if (stray) begin
      sd_dst = 1'b1; sd_rdy = 1'b1; sd_din = 16'hBAD0;
      tick();
      sd_dst = 1'b0; sd_rdy = 1'b0;
    end
    check("sd_rd_held", b1.sd_rd, 1);
    check("rr_sd_addr_hold", b1.sd_addr, a_rr);
    sd_ack = 1'b1;
    if (same) begin sd_dst = 1'b1; sd_din = lo; end
    tick();
    sd_ack = 1'b0; sd_dst = 1'b0;
    check("sd_rd_after_ack", b1.sd_rd, 0);
    if (!same) begin
      if (stray) begin
        sd_rdy = 1'b1; sd_din = 16'hBAD1;
        tick();
        sd_rdy = 1'b0;
      end
      sd_dst = 1'b1; sd_din = lo;
      tick();
      sd_dst = 1'b0;
    end
    sd_rdy = 1'b1; sd_din = hi;
    tick();
    sd_rdy = 1'b0; sd_din = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit ok;
    int n;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    sd_ack = 1'b0; sd_dst = 1'b0; sd_rdy = 1'b0; sd_din = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {b1.sd_rd, b1.din_ok, b1.we0, b1.we1, b1.err}, 5'b0);
    check("rst_din", b1.din, 32'h0);
    check("rst_sd_addr", b1.sd_addr, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Tie: RR serves 0,1,0; fixed priority keeps serving 0 until req0 drops
    addr0 = 22'd10; addr1 = 22'd20;
    req0 = 1'b1; req1 = 1'b1;
    expect2(1'b0, 1'b0, 32'hA0011111);
    serve(1, 0, 0, 0, 16'h1111, 16'hA001, 22'd10, 22'd10);
    expect2(1'b1, 1'b0, 32'hA0022222);
    serve(1, 0, 0, 0, 16'h2222, 16'hA002, 22'd20, 22'd10);
    expect2(1'b0, 1'b0, 32'hA0033333);
    serve(1, 0, 0, 0, 16'h3333, 16'hA003, 22'd10, 22'd10);
    req0 = 1'b0;
    expect2(1'b1, 1'b1, 32'hA0044444);
    serve(1, 0, 0, 0, 16'h4444, 16'hA004, 22'd20, 22'd20);
    req1 = 1'b0;
    tick();

    // Single read with stray strobes in WAIT_ACK and WAIT_DST
    addr0 = 22'h01234; req0 = 1'b1;
    expect2(1'b0, 1'b0, 32'hDEADBEEF);
    serve(3, 0, 1, 0, 16'hBEEF, 16'hDEAD, 22'h01234, 22'h01234);
    req0 = 1'b0;
    tick();
    check("post_idle", {b1.din_ok, b1.sd_rd}, 2'b00);

    // ack and dst in the same cycle, maximum address
    addr1 = 22'h3FFFFF; req1 = 1'b1;
    expect2(1'b1, 1'b1, 32'hFFFF0001);
    serve(2, 1, 0, 0, 16'h0001, 16'hFFFF, 22'h3FFFFF, 22'h3FFFFF);
    req1 = 1'b0;
    tick();

    // Requester drops and changes address before ack
    addr0 = 22'h2AAAA; req0 = 1'b1;
    expect2(1'b0, 1'b0, 32'h12345678);
    serve(3, 0, 0, 1, 16'h5678, 16'h1234, 22'h2AAAA, 22'h2AAAA);
    tick();

    // Reset in WAIT_RDY; a late sd_rdy must not produce din_ok
    addr0 = 22'h00007; req0 = 1'b1;
    wait_rd(ok);
    tick();
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0; sd_dst = 1'b1; sd_din = 16'h1234;
    tick();
    sd_dst = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {b1.sd_rd, b1.din_ok, b1.we0, b1.we1, b1.err}, 5'b0);
    check("rst_mid_din", b1.din, 32'h0);
    check("rst_mid_sd_addr", b1.sd_addr, '0);
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sd_rdy = 1'b1; sd_din = 16'hABCD;
    tick();
    sd_rdy = 1'b0; sd_din = '0;
    check("late_rdy_no_din_ok", {b1.din_ok, b1.din}, 33'h0);
    tick();

`ifdef JTFRAME_ROMRSP_TIMEOUT_EN
    // Watchdog: no ack, sd_rd drops after TOUT cycles, then a normal re-grant
    addr0 = 22'h00100; req0 = 1'b1;
    wait_rd(ok);
    n = 0;
    while (b1.sd_rd && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tout_cycles", n, TOUT);
    check("tout_err", {b1.err, b0.err}, 2'b11);
    expect2(1'b0, 1'b0, 32'h00C000C1);
    serve(1, 0, 0, 0, 16'h00C1, 16'h00C0, 22'h00100, 22'h00100);
    req0 = 1'b0;
    tick();
    check("err_sticky", {b1.err, b0.err}, 2'b11);
`else
    n = 0;
    check("err_tied_low", {b1.err, b0.err}, 2'b00);
`endif

    repeat (4) tick();
    check("scoreboard_drained", q1.size() + q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtframe_romrsp.md
Name: jtframe_romrsp

Overview:
- SDRAM-side responder serving two ROM-request clients.
- Each client issues a level `req` with a 22-bit word address and expects a shared 32-bit `din`, plus a `din_ok` strobe and a per-client `we` select.
- Arbitrates between the clients and issues one read burst to the SDRAM controller.
- Assembles two 16-bit halfwords into the 32-bit word and delivers it to the granted client.
- Sits between the game-side request blocks and the SDRAM controller in the jtframe memory path.

Parameters:
- AW, 22, address width for client and SDRAM addresses.
- RR, 1, arbitration mode: 1 = round-robin; 0 = fixed priority, client 0 wins.
- TOUT, 255, watchdog limit in clock cycles; used only with JTFRAME_ROMRSP_TIMEOUT_EN; must be ≥ 16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0  in  1  client 0 request level.
- addr0  in  AW  client 0 SDRAM word address.
- req1  in  1  client 1 request level.
- addr1  in  AW  client 1 SDRAM word address.
- din  out  32  data word, shared by both clients.
- din_ok  out  1  one-cycle strobe; `din` is valid.
- we0  out  1  `din` belongs to client 0; asserted only together with `din_ok`.
- we1  out  1  `din` belongs to client 1; asserted only together with `din_ok`.
- sd_rd  out  1  read request to the SDRAM controller.
- sd_addr  out  AW  address latched at grant.
- sd_ack  in  1  one-cycle pulse: controller accepted the request.
- sd_dst  in  1  one-cycle pulse: low halfword is on `sd_din`.
- sd_rdy  in  1  one-cycle pulse: high halfword is on `sd_din`; burst done.
- sd_din  in  16  SDRAM read data.
- err  out  1  sticky timeout flag; constant 0 without the macro.

Behaviour:
- Reset (rst_n low, any state): all outputs 0, `din` = 0, FSM to IDLE, round-robin pointer = client 0 preferred.
- FSM states: IDLE, WAIT_ACK, WAIT_DST, WAIT_RDY, POST.
- IDLE:
  - Sample req0/req1.
  - If any is high: grant one, latch its address into `sd_addr`, set `sd_rd` = 1 registered, go to WAIT_ACK.
  - Grant takes effect 1 cycle after `req` rises.
- Arbitration:
  - RR = 1: on a tie, the client not served last wins.
  - RR = 0: client 0 always wins.
  - A single requester is always granted.
- WAIT_ACK:
  - Hold `sd_rd` and `sd_addr` until `sd_ack`.
  - On `sd_ack`: `sd_rd` = 0 next cycle, go to WAIT_DST.
  - If `sd_ack` and `sd_dst` arrive in the same cycle: latch the low halfword and go straight to WAIT_RDY.
- WAIT_DST: on `sd_dst`, latch `sd_din` as the low half, go to WAIT_RDY.
- WAIT_RDY, on `sd_rdy`:
  - Register `din` = {sd_din, low}.
  - `din_ok` = 1 and the granted `we` = 1 for exactly the next cycle.
  - Go to POST.
- Latency: `sd_rdy` at cycle N → `din_ok` at N+1.
- POST:
  - Lasts one cycle; `req` inputs are ignored.
  - The client's cache updates on `din_ok`, so its `req` drops within this cycle.
  - Then return to IDLE.
- A client lowering `req` after grant does not abort the burst.
  - The transaction completes and data is still delivered with its `we`.
  - `sd_rd` is never withdrawn before `sd_ack`.
- Address changes on the granted client after grant are ignored; the latched address is used.
- Stray `sd_dst`/`sd_rdy` in IDLE, WAIT_ACK or POST are ignored.
- `sd_rdy` in WAIT_DST is ignored.
- `we0` and `we1` are never high together; neither is high without `din_ok`.

Optional Feature:
- Macro: JTFRAME_ROMRSP_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in WAIT_ACK/WAIT_DST/WAIT_RDY and clears on each state change.
  - At TOUT cycles: drop `sd_rd`, return to IDLE without `din_ok`, set `err` = 1 (cleared only by reset).
  - The same client may be re-granted.
- Undefined: no counter; the FSM waits forever; `err` tied to 0.

Decomposition:
- Package jtframe_romrsp_pkg:
  - FSM state encoding (3-bit).
  - Halfword width constant HW = 16.
  - Client count NCLI = 2.
- Sub-module jtframe_romrsp_arb: 2-way arbiter.
  - Inputs: req vector, RR, last-served bit.
  - Outputs: grant and valid.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single read: req0 = 1, addr0 = 22'h01234; controller acks after 3 cycles, dst = 16'hBEEF, rdy = 16'hDEAD → sd_addr = 22'h01234; one cycle later din = 32'hDEADBEEF, din_ok = 1, we0 = 1, we1 = 0; then POST, IDLE.
- Tie, RR = 1: req0 = req1 = 1 held, addr0 = 10, addr1 = 20 → served in order 0, 1, 0; sd_addr sequence 10, 20, 10.
- Tie, RR = 0: same stimulus → always client 0; client 1 starves while req0 stays high.
- req0 drops one cycle after grant, before sd_ack → sd_rd held until ack, data still delivered with we0 = 1.
- rst_n pulled low in WAIT_RDY → all outputs 0 immediately; after release, a late sd_rdy produces no din_ok.
- With JTFRAME_ROMRSP_TIMEOUT_EN, TOUT = 16, sd_ack never asserted → sd_rd falls after 16 cycles, err = 1, no din_ok; the next request is still served normally.
